// File: rtl/fme_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fme_pkg : shared widths, mode and column-engine state types. Rev 1.0
// ------------------------------------------------------------------
package fme_pkg;

  typedef enum logic {
    MODE_SATD = 1'b0,
    MODE_SAD  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COL  = 2'd1,
    ST_HOLD = 2'd2
  } col_state_e;

  function automatic int diff_w(input int pix_w);
    return pix_w + 1;
  endfunction

  function automatic int row_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int col_w(input int pix_w);
    return pix_w + 5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hadamard4.sv
`default_nettype none
// ------------------------------------------------------------------
// hadamard4 : combinational 4-point butterfly, output 2 bits wider. Rev 1.0
// ------------------------------------------------------------------
module hadamard4 #(
  parameter int IN_W = 9
) (
  input  logic signed [IN_W-1:0] a_i,
  input  logic signed [IN_W-1:0] b_i,
  input  logic signed [IN_W-1:0] c_i,
  input  logic signed [IN_W-1:0] e_i,
  output logic signed [IN_W+1:0] o0_o,
  output logic signed [IN_W+1:0] o1_o,
  output logic signed [IN_W+1:0] o2_o,
  output logic signed [IN_W+1:0] o3_o
);
  localparam int OW = IN_W + 2;

  logic signed [OW-1:0] w_a, w_b, w_c, w_e;

  assign w_a = OW'(a_i);
  assign w_b = OW'(b_i);
  assign w_c = OW'(c_i);
  assign w_e = OW'(e_i);

  assign o0_o = w_a + w_b + w_c + w_e;
  assign o1_o = (w_b - w_c) + (w_a - w_e);
  assign o2_o = (w_a + w_e) - (w_b + w_c);
  assign o3_o = (w_a - w_e) - (w_b - w_c);

endmodule
`default_nettype wire

// File: rtl/satd_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// satd_engine : streaming 4x4 SATD / SAD distortion per prediction unit. Rev 1.0
// ------------------------------------------------------------------
module satd_engine
  import fme_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int N_BLK  = 4,
  parameter int DIST_W = PIX_W + 8 + ((N_BLK > 1) ? $clog2(N_BLK) : 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [4*PIX_W-1:0] cur_row_i,
  input  logic [4*PIX_W-1:0] ref_row_i,
  output logic               dist_valid_o,
  input  logic               dist_ready_i,
  output logic [DIST_W-1:0]  dist_o
);
  localparam int DW = diff_w(PIX_W);
  localparam int RW = row_w(PIX_W);
  localparam int CW = col_w(PIX_W);
  localparam int AW = DIST_W + 1;
  localparam int BW = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(N_BLK - 1);

  logic [1:0]          row_q;
  logic [BW-1:0]       blk_q;
  logic                wb_q, rb_q, init_q;
  logic [1:0]          full_q, bank_last_q;
  mode_e               mode_q, pend_mode_q;
  mode_e               bank_mode_q [2];
  logic [RW-1:0]       tbuf_q [2][4][4];
  col_state_e          state_q;
  logic [1:0]          col_q;
  logic [AW-1:0]       acc_q;
  logic                dist_valid_q;
  logic [DIST_W-1:0]   dist_q;

  logic                 w_acc, w_rel, w_out_free;
  mode_e                w_mode, w_rd_mode;
  logic [1:0]           w_set, w_clr;
  logic signed [DW-1:0] w_d  [4];
  logic [DW-1:0]        w_ad [4];
  logic signed [RW-1:0] w_h  [4];
  logic [RW-1:0]        w_wr [4];
  logic [RW-1:0]        w_cv [4];
  logic signed [CW-1:0] w_co [4];
  logic [CW-1:0]        w_ca [4];
  logic [AW-1:0]        w_col_sum, w_acc_sum;

  function automatic logic [DIST_W-1:0] finish(input logic [AW-1:0] s, input mode_e m);
    logic [AW-1:0] r;
    r = (m == MODE_SATD) ? ((s + AW'(1)) >> 1) : s;
    return DIST_W'(r);
  endfunction

  // Mode of row 0 of block 0 comes straight from the port; later rows use the latched copy.
  assign w_mode     = (row_q == 2'd0 && blk_q == '0) ? mode_e'(mode_i) : mode_q;
  assign w_set      = (w_acc && row_q == 2'd3) ? (2'b01 << wb_q) : 2'b00;
  assign w_clr      = (state_q == ST_COL && col_q == 2'd3) ? (2'b01 << rb_q) : 2'b00;
  assign w_rel      = w_clr[wb_q];
  assign in_ready_o = init_q & (~full_q[wb_q] | w_rel);
  assign w_acc      = in_valid_i & in_ready_o;
  assign w_out_free = ~dist_valid_q | dist_ready_i;
  assign w_rd_mode  = bank_mode_q[rb_q];

  for (genvar k = 0; k < 4; k++) begin : g_pix
    assign w_d[k]  = $signed({1'b0, cur_row_i[k*PIX_W +: PIX_W]})
                   - $signed({1'b0, ref_row_i[k*PIX_W +: PIX_W]});
    assign w_ad[k] = w_d[k][DW-1] ? $unsigned(-w_d[k]) : $unsigned(w_d[k]);
    assign w_wr[k] = (w_mode == MODE_SAD) ? {2'b00, w_ad[k]} : $unsigned(w_h[k]);
    assign w_cv[k] = tbuf_q[rb_q][k][col_q];
    assign w_ca[k] = w_co[k][CW-1] ? $unsigned(-w_co[k]) : $unsigned(w_co[k]);
  end

  hadamard4 #(.IN_W(DW)) u_row_h (
    .a_i (w_d[0]), .b_i (w_d[1]), .c_i (w_d[2]), .e_i (w_d[3]),
    .o0_o(w_h[0]), .o1_o(w_h[1]), .o2_o(w_h[2]), .o3_o(w_h[3])
  );

  hadamard4 #(.IN_W(RW)) u_col_h (
    .a_i ($signed(w_cv[0])), .b_i ($signed(w_cv[1])),
    .c_i ($signed(w_cv[2])), .e_i ($signed(w_cv[3])),
    .o0_o(w_co[0]), .o1_o(w_co[1]), .o2_o(w_co[2]), .o3_o(w_co[3])
  );

  assign w_col_sum = (w_rd_mode == MODE_SATD)
                   ? AW'(w_ca[0]) + AW'(w_ca[1]) + AW'(w_ca[2]) + AW'(w_ca[3])
                   : AW'(w_cv[0]) + AW'(w_cv[1]) + AW'(w_cv[2]) + AW'(w_cv[3]);
  assign w_acc_sum = acc_q + w_col_sum;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int k = 0; k < 4; k++) tbuf_q[wb_q][row_q][k] <= w_wr[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q          <= '0;
      blk_q          <= '0;
      wb_q           <= 1'b0;
      init_q         <= 1'b0;
      mode_q         <= MODE_SATD;
      bank_mode_q[0] <= MODE_SATD;
      bank_mode_q[1] <= MODE_SATD;
      bank_last_q    <= '0;
      full_q         <= '0;
    end else begin
      init_q <= 1'b1;
      full_q <= (full_q & ~w_clr) | w_set;
      if (w_acc) begin
        mode_q <= w_mode;
        row_q  <= row_q + 2'd1;
        if (row_q == 2'd3) begin
          wb_q              <= ~wb_q;
          bank_mode_q[wb_q] <= w_mode;
          bank_last_q[wb_q] <= (blk_q == LAST_BLK);
          blk_q             <= (blk_q == LAST_BLK) ? '0 : blk_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      rb_q         <= 1'b0;
      acc_q        <= '0;
      pend_mode_q  <= MODE_SATD;
      dist_valid_q <= 1'b0;
      dist_q       <= '0;
    end else begin
      if (dist_ready_i) dist_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          col_q <= '0;
          if (full_q[rb_q]) state_q <= ST_COL;
        end
        ST_COL: begin
          col_q <= col_q + 2'd1;
          acc_q <= w_acc_sum;
          if (col_q == 2'd3) begin
            rb_q    <= ~rb_q;
            state_q <= full_q[~rb_q] ? ST_COL : ST_IDLE;
            if (bank_last_q[rb_q]) begin
              if (w_out_free) begin
                dist_q       <= finish(w_acc_sum, w_rd_mode);
                dist_valid_q <= 1'b1;
                acc_q        <= '0;
              end else begin
                // The finished PU parks in the accumulator until the output register frees.
                pend_mode_q <= w_rd_mode;
                state_q     <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          col_q <= '0;
          if (w_out_free) begin
            dist_q       <= finish(acc_q, pend_mode_q);
            dist_valid_q <= 1'b1;
            acc_q        <= '0;
            state_q      <= full_q[rb_q] ? ST_COL : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dist_valid_o = dist_valid_q;
  assign dist_o       = dist_q;

endmodule
`default_nettype wire

// File: tb/tb_satd_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_satd_engine : randomized scoreboard bench, N_BLK=1 and N_BLK=4 instances. Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_satd_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode       [2] = '{1'b0, 1'b0};
  logic        in_valid   [2] = '{1'b0, 1'b0};
  logic [31:0] cur_row    [2] = '{32'd0, 32'd0};
  logic [31:0] ref_row    [2] = '{32'd0, 32'd0};
  logic        dist_ready [2] = '{1'b1, 1'b1};
  logic        in_ready   [2];
  logic        dist_valid [2];
  logic [16:0] dist_a;
  logic [17:0] dist_b;
  logic [17:0] dist_v     [2];

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          rdy_mode [2] = '{0, 0};
  int          lat_acc  [2] = '{-1, -1};
  int          acc_cyc  [2] = '{0, 0};
  bit          prev_hold  [2] = '{1'b0, 1'b0};
  bit          prev_valid [2] = '{1'b0, 1'b0};
  logic [17:0] prev_dist  [2];
  bit          bp_phase = 1'b0;
  int          stall_cnt = 0;
  longint      exp_q0 [$];
  longint      exp_q1 [$];
  int          pu_d [4][4][4];

  satd_engine #(.PIX_W(8), .N_BLK(1)) u_dut0 (
    .clk(clk), .rst(rst), .mode_i(mode[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .cur_row_i(cur_row[0]), .ref_row_i(ref_row[0]), .dist_valid_o(dist_valid[0]),
    .dist_ready_i(dist_ready[0]), .dist_o(dist_a)
  );

  satd_engine #(.PIX_W(8), .N_BLK(4)) u_dut1 (
    .clk(clk), .rst(rst), .mode_i(mode[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .cur_row_i(cur_row[1]), .ref_row_i(ref_row[1]), .dist_valid_o(dist_valid[1]),
    .dist_ready_i(dist_ready[1]), .dist_o(dist_b)
  );

  assign dist_v[0] = {1'b0, dist_a};
  assign dist_v[1] = dist_b;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      case (rdy_mode[u])
        0:       dist_ready[u] <= 1'b1;
        1:       dist_ready[u] <= ($urandom_range(0, 3) != 0);
        default: dist_ready[u] <= 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input int u, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[u%0d]: got %0d expected %0d (t=%0t)", name, u, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic longint pop_exp(input int u);
    if (u == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void push_exp(input int u, input longint e);
    if (u == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference: 2-D Hadamard as a matrix product H*D*H^T per block, or plain |d| for SAD.
  function automatic longint model(input int nb, input bit sad);
    int     hm [4][4];
    longint s;
    int     t;
    hm = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
    s = 0;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          if (sad) s += iabs(pu_d[b][i][j]);
          else begin
            t = 0;
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++) t += hm[i][r] * pu_d[b][r][c] * hm[j][c];
            s += iabs(t);
          end
        end
    return sad ? s : (s + 1) / 2;
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        prev_hold[u]  = 1'b0;
        prev_valid[u] = 1'b0;
      end else begin
        if (prev_hold[u]) begin
          chk("hold_valid", u, longint'(dist_valid[u]), 1);
          chk("hold_data", u, longint'(dist_v[u]), longint'(prev_dist[u]));
        end
        if (dist_valid[u] && !prev_valid[u] && lat_acc[u] >= 0) begin
          chk("latency", u, cycle - lat_acc[u], 5);
          lat_acc[u] = -1;
        end
        if (dist_valid[u] && dist_ready[u]) begin
          if (qsize(u) == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_result[u%0d]: got %0d expected none", u, dist_v[u]);
          end else chk("dist", u, longint'(dist_v[u]), pop_exp(u));
        end
        prev_hold[u]  = dist_valid[u] && !dist_ready[u];
        prev_valid[u] = dist_valid[u];
        prev_dist[u]  = dist_v[u];
      end
    end
    if (bp_phase && in_valid[1] && !in_ready[1]) stall_cnt++;
  end

  task automatic send_row(input int u, input logic [31:0] cr, input logic [31:0] rr, input bit m);
    int n;
    in_valid[u] = 1'b1;
    cur_row[u]  = cr;
    ref_row[u]  = rr;
    mode[u]     = m;
    n = 0;
    while (!in_ready[u] && n <= 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n > 300) begin
      chk("in_ready_timeout", u, 0, 1);
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc[u] = cycle;
  endtask

  // pat: 0 random, 1 cur=10/ref=9, 2 unit impulse at (0,0), 3 cur=255/ref=0, 4 all zero
  task automatic run_pu(input int u, input int pat, input bit m, input bit toggle,
                        input bit lat, input longint exp_ovr);
    int          nb;
    int          cv, rv, idx;
    logic [31:0] cr [16];
    logic [31:0] rr [16];
    nb = (u == 0) ? 1 : 4;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          case (pat)
            0: begin cv = int'($urandom_range(0, 255)); rv = int'($urandom_range(0, 255)); end
            1: begin cv = 10; rv = 9; end
            2: begin cv = (b == 0 && r == 0 && k == 0) ? 1 : 0; rv = 0; end
            3: begin cv = 255; rv = 0; end
            default: begin cv = 0; rv = 0; end
          endcase
          idx = b * 4 + r;
          cr[idx][k*8 +: 8] = cv[7:0];
          rr[idx][k*8 +: 8] = rv[7:0];
          pu_d[b][r][k] = cv - rv;
        end
    push_exp(u, (exp_ovr >= 0) ? exp_ovr : model(nb, m));
    for (int i = 0; i < nb * 4; i++) send_row(u, cr[i], rr[i], toggle ? (m ^ i[0]) : m);
    if (lat) lat_acc[u] = acc_cyc[u];
    in_valid[u] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qsize(0) != 0 || qsize(1) != 0 || dist_valid[0] || dist_valid[1]) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 0, qsize(0) + qsize(1), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_in_ready", u, longint'(in_ready[u]), 0);
      chk("rst_dist_valid", u, longint'(dist_valid[u]), 0);
      chk("rst_dist", u, longint'(dist_v[u]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) chk("post_rst_in_ready", u, longint'(in_ready[u]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    run_pu(0, 1, 1'b0, 1'b0, 1'b1, 8);
    drain();
    run_pu(0, 2, 1'b0, 1'b0, 1'b0, 8);
    run_pu(0, 2, 1'b1, 1'b0, 1'b0, 1);
    run_pu(1, 3, 1'b0, 1'b0, 1'b1, 8160);
    run_pu(1, 3, 1'b1, 1'b0, 1'b0, 16320);
    drain();

    run_pu(1, 0, 1'b0, 1'b1, 1'b0, -1);
    run_pu(1, 0, 1'b1, 1'b1, 1'b0, -1);
    drain();

    rdy_mode[1] = 2;
    bp_phase = 1'b1;
    fork
      begin
        run_pu(1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_pu(1, 0, 1'b1, 1'b0, 1'b0, -1);
        run_pu(1, 3, 1'b0, 1'b0, 1'b0, 8160);
      end
      begin
        repeat (60) @(posedge clk);
        #1;
        rdy_mode[1] = 0;
      end
    join
    bp_phase = 1'b0;
    drain();
    chk("backpressure_stall_seen", 1, longint'(stall_cnt > 0), 1);

    send_row(1, $urandom(), $urandom(), 1'b0);
    send_row(1, $urandom(), $urandom(), 1'b0);
    do_reset();
    run_pu(1, 4, 1'b0, 1'b0, 1'b0, 0);
    drain();

    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    fork
      for (int i = 0; i < 8; i++)
        run_pu(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
      for (int j = 0; j < 6; j++)
        run_pu(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
    join
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
